// File: rtl/init_reset_sequencer.sv
// Sequences fabric reset release and IOD training start from the device init monitor status
// (POR, init done, per-bank calibration) and the SCLK PLL lock.
module init_reset_sequencer #(
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned CALIB_TIMEOUT  = 1000000
) (
  input  logic                 SCLK,
  input  logic                 RESETN,
  input  logic                 FABRIC_POR_N,
  input  logic                 DEVICE_INIT_DONE,
  input  logic [NUM_BANKS-1:0] BANK_CALIB_STATUS,
  input  logic                 PLL_LOCK,
  output logic                 FABRIC_RESET_N,
  output logic                 IOD_TRAIN_START,
  output logic                 CALIB_TIMEOUT_ERR,
  output logic [2:0]           SEQ_STATE
);

  localparam int unsigned NUM_ASYNC = NUM_BANKS + 3;
  localparam int unsigned STRETCH_W = 16;
  localparam int unsigned TIMEOUT_W = 24;

  localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(STRETCH_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL  = TIMEOUT_W'(CALIB_TIMEOUT);

  typedef enum logic [2:0] {
    ST_WAIT_POR   = 3'd0,
    ST_WAIT_INIT  = 3'd1,
    ST_WAIT_CALIB = 3'd2,
    ST_WAIT_LOCK  = 3'd3,
    ST_STRETCH    = 3'd4,
    ST_RUN        = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [STRETCH_W-1:0]   stretch_cnt_q, stretch_cnt_d;
  logic [TIMEOUT_W-1:0]   calib_cnt_q, calib_cnt_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   fabric_reset_n_q, fabric_reset_n_d;
  logic                   train_start_q, train_start_d;

  logic [NUM_ASYNC-1:0]   async_in;
  logic [NUM_ASYNC-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_ASYNC-1:0]   sync_out;
  logic                   por_n_s;
  logic                   init_done_s;
  logic                   cal_ok;
  logic                   lock_s;
  logic                   state_legal;

  // One synchronizer chain per async status bit, all packed side by side.
  assign async_in = {PLL_LOCK, BANK_CALIB_STATUS, DEVICE_INIT_DONE, FABRIC_POR_N};

  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= async_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_out    = sync_q[SYNC_STAGES-1];
  assign por_n_s     = sync_out[0];
  assign init_done_s = sync_out[1];
  assign cal_ok      = &sync_out[NUM_BANKS+1:2];
  assign lock_s      = sync_out[NUM_ASYNC-1];
  assign state_legal = (3'(state_q) <= 3'(ST_RUN));

  // State register.
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_WAIT_POR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: normal progression first, then POR / init-done overrides on top.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_POR: begin
        if (por_n_s) state_d = ST_WAIT_INIT;
      end
      ST_WAIT_INIT: begin
        if (init_done_s) state_d = ST_WAIT_CALIB;
      end
      ST_WAIT_CALIB: begin
        if (cal_ok) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) state_d = ST_STRETCH;
      end
      ST_STRETCH: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (stretch_cnt_q == STRETCH_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!cal_ok) begin
          state_d = ST_WAIT_CALIB;
        end else if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      default: state_d = ST_WAIT_POR;
    endcase

    if (!por_n_s) begin
      state_d = ST_WAIT_POR;
    end else if (!init_done_s && state_legal) begin
      state_d = ST_WAIT_INIT;
    end
  end

  // Counters, sticky timeout flag and registered outputs, all derived from the state transition.
  always_comb begin
    stretch_cnt_d    = '0;
    calib_cnt_d      = calib_cnt_q;
    timeout_err_d    = timeout_err_q;
    fabric_reset_n_d = (state_d == ST_RUN);
    train_start_d    = (state_d == ST_RUN) && (state_q != ST_RUN);

    if ((state_q == ST_STRETCH) && (state_d == ST_STRETCH)) begin
      stretch_cnt_d = stretch_cnt_q + STRETCH_W'(1);
    end

    if ((state_d == ST_WAIT_CALIB) && (state_q != ST_WAIT_CALIB)) begin
      calib_cnt_d = '0;
    end else if ((state_q == ST_WAIT_CALIB) && (calib_cnt_q != TIMEOUT_VAL)) begin
      calib_cnt_d = calib_cnt_q + TIMEOUT_W'(1);
    end

    if ((state_q == ST_WAIT_CALIB) && (calib_cnt_d == TIMEOUT_VAL)) begin
      timeout_err_d = 1'b1;
    end
    if (state_d == ST_WAIT_POR) begin
      timeout_err_d = 1'b0;
    end
  end

  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      stretch_cnt_q    <= '0;
      calib_cnt_q      <= '0;
      timeout_err_q    <= 1'b0;
      fabric_reset_n_q <= 1'b0;
      train_start_q    <= 1'b0;
    end else begin
      stretch_cnt_q    <= stretch_cnt_d;
      calib_cnt_q      <= calib_cnt_d;
      timeout_err_q    <= timeout_err_d;
      fabric_reset_n_q <= fabric_reset_n_d;
      train_start_q    <= train_start_d;
    end
  end

  assign FABRIC_RESET_N    = fabric_reset_n_q;
  assign IOD_TRAIN_START   = train_start_q;
  assign CALIB_TIMEOUT_ERR = timeout_err_q;
  assign SEQ_STATE         = 3'(state_q);

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Bench for init_reset_sequencer: table of {inputs, cycles, expected outputs} rows,
// followed by hand-written stretch-abort and asynchronous-reset sequences.
module tb_init_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       por_n;
  logic       init_done;
  logic [3:0] bank;
  logic       lock;
  logic       fab_rst_n;
  logic       train;
  logic       terr;
  logic [2:0] st;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  init_reset_sequencer #(
    .NUM_BANKS      (4),
    .SYNC_STAGES    (2),
    .STRETCH_CYCLES (16),
    .CALIB_TIMEOUT  (64)
  ) dut (
    .SCLK              (clk),
    .RESETN            (rst_n),
    .FABRIC_POR_N      (por_n),
    .DEVICE_INIT_DONE  (init_done),
    .BANK_CALIB_STATUS (bank),
    .PLL_LOCK          (lock),
    .FABRIC_RESET_N    (fab_rst_n),
    .IOD_TRAIN_START   (train),
    .CALIB_TIMEOUT_ERR (terr),
    .SEQ_STATE         (st)
  );

  typedef struct {
    string       name;
    logic        rstn;
    logic        por;
    logic        ini;
    logic [3:0]  bnk;
    logic        lck;
    int unsigned cyc;
    logic [2:0]  est;
    logic        efab;
    logic        eiod;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic rstn_v, input logic por_v, input logic ini_v,
                     input logic [3:0] bnk_v, input logic lck_v, input int unsigned cyc_v,
                     input logic [2:0] est_v, input logic efab_v, input logic eiod_v,
                     input logic eerr_v);
    vec_t v;
    v.name = n;  v.rstn = rstn_v; v.por = por_v;  v.ini = ini_v;   v.bnk = bnk_v;
    v.lck = lck_v; v.cyc = cyc_v; v.est = est_v; v.efab = efab_v; v.eiod = eiod_v;
    v.eerr = eerr_v;
    vecs.push_back(v);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int unsigned n_str;
    logic        done;
    logic        iod_seen;
    logic        fab_seen;

    // name        rstn por ini bank     lck cyc  st fab iod err
    add("t1_rst",    0, 1, 1, 4'b1111, 1,  3,  0, 0, 0, 0);
    add("t1_sync",   1, 1, 1, 4'b1111, 1,  2,  0, 0, 0, 0);
    add("t1_init",   1, 1, 1, 4'b1111, 1,  1,  1, 0, 0, 0);
    add("t1_calib",  1, 1, 1, 4'b1111, 1,  1,  2, 0, 0, 0);
    add("t1_lock",   1, 1, 1, 4'b1111, 1,  1,  3, 0, 0, 0);
    add("t1_str",    1, 1, 1, 4'b1111, 1,  1,  4, 0, 0, 0);
    add("t1_e21",    1, 1, 1, 4'b1111, 1, 15,  4, 0, 0, 0);
    add("t1_e22",    1, 1, 1, 4'b1111, 1,  1,  5, 1, 1, 0);
    add("t1_e23",    1, 1, 1, 4'b1111, 1,  1,  5, 1, 0, 0);
    add("t2_rst",    0, 0, 0, 4'b0000, 0,  2,  0, 0, 0, 0);
    add("t2_idle",   1, 0, 0, 4'b0000, 0, 50,  0, 0, 0, 0);
    add("t2_por_s",  1, 1, 0, 4'b0000, 0,  2,  0, 0, 0, 0);
    add("t2_por",    1, 1, 0, 4'b0000, 0,  1,  1, 0, 0, 0);
    add("t2_por_h",  1, 1, 0, 4'b0000, 0, 47,  1, 0, 0, 0);
    add("t2_ini_s",  1, 1, 1, 4'b0000, 0,  2,  1, 0, 0, 0);
    add("t2_ini",    1, 1, 1, 4'b0000, 0,  1,  2, 0, 0, 0);
    add("t2_ini_h",  1, 1, 1, 4'b0000, 0, 47,  2, 0, 0, 0);
    add("t2_b0_63",  1, 1, 1, 4'b0001, 0, 16,  2, 0, 0, 0);
    add("t2_b0_64",  1, 1, 1, 4'b0001, 0,  1,  2, 0, 0, 1);
    add("t2_b0_h",   1, 1, 1, 4'b0001, 0, 33,  2, 0, 0, 1);
    add("t2_b1",     1, 1, 1, 4'b0011, 0, 50,  2, 0, 0, 1);
    add("t2_b2",     1, 1, 1, 4'b0111, 0, 50,  2, 0, 0, 1);
    add("t2_b3_s",   1, 1, 1, 4'b1111, 0,  2,  2, 0, 0, 1);
    add("t2_b3",     1, 1, 1, 4'b1111, 0,  1,  3, 0, 0, 1);
    add("t2_b3_h",   1, 1, 1, 4'b1111, 0, 47,  3, 0, 0, 1);
    add("t2_lk_s",   1, 1, 1, 4'b1111, 1,  2,  3, 0, 0, 1);
    add("t2_lk",     1, 1, 1, 4'b1111, 1,  1,  4, 0, 0, 1);
    add("t2_lk_18",  1, 1, 1, 4'b1111, 1, 15,  4, 0, 0, 1);
    add("t2_run",    1, 1, 1, 4'b1111, 1,  1,  5, 1, 1, 1);
    add("t2_run2",   1, 1, 1, 4'b1111, 1,  1,  5, 1, 0, 1);
    add("t3_drop_s", 1, 1, 1, 4'b1111, 0,  2,  5, 1, 0, 1);
    add("t3_drop",   1, 1, 1, 4'b1111, 0,  1,  3, 0, 0, 1);
    add("t3_hold",   1, 1, 1, 4'b1111, 0,  7,  3, 0, 0, 1);
    add("t3_rel_s",  1, 1, 1, 4'b1111, 1,  2,  3, 0, 0, 1);
    add("t3_rel",    1, 1, 1, 4'b1111, 1,  1,  4, 0, 0, 1);
    add("t3_rel_15", 1, 1, 1, 4'b1111, 1, 15,  4, 0, 0, 1);
    add("t3_run",    1, 1, 1, 4'b1111, 1,  1,  5, 1, 1, 1);
    add("t3_run2",   1, 1, 1, 4'b1111, 1,  1,  5, 1, 0, 1);
    add("t5_drop_s", 1, 0, 1, 4'b1111, 0,  2,  5, 1, 0, 1);
    add("t5_drop",   1, 0, 1, 4'b1111, 0,  1,  0, 0, 0, 0);
    add("t4_start",  1, 1, 1, 4'b1011, 1,  3,  1, 0, 0, 0);
    add("t4_cal",    1, 1, 1, 4'b1011, 1,  1,  2, 0, 0, 0);
    add("t4_63",     1, 1, 1, 4'b1011, 1, 63,  2, 0, 0, 0);
    add("t4_64",     1, 1, 1, 4'b1011, 1,  1,  2, 0, 0, 1);
    add("t4_hold",   1, 1, 1, 4'b1011, 1, 20,  2, 0, 0, 1);
    add("t4_b2_s",   1, 1, 1, 4'b1111, 1,  2,  2, 0, 0, 1);
    add("t4_b2",     1, 1, 1, 4'b1111, 1,  1,  3, 0, 0, 1);
    add("t4_str",    1, 1, 1, 4'b1111, 1,  1,  4, 0, 0, 1);
    add("t4_str15",  1, 1, 1, 4'b1111, 1, 15,  4, 0, 0, 1);
    add("t4_run",    1, 1, 1, 4'b1111, 1,  1,  5, 1, 1, 1);
    add("t4_por0",   1, 0, 1, 4'b1111, 1,  1,  5, 1, 0, 1);
    add("t4_por1",   1, 1, 1, 4'b1111, 1,  1,  5, 1, 0, 1);
    add("t4_porc",   1, 1, 1, 4'b1111, 1,  1,  0, 0, 0, 0);
    add("t4_rest",   1, 1, 1, 4'b1111, 1,  1,  1, 0, 0, 0);

    rst_n = 1'b0; por_n = 1'b1; init_done = 1'b1; bank = 4'hF; lock = 1'b1;

    foreach (vecs[i]) begin
      rst_n     = vecs[i].rstn;
      por_n     = vecs[i].por;
      init_done = vecs[i].ini;
      bank      = vecs[i].bnk;
      lock      = vecs[i].lck;
      tick(vecs[i].cyc);
      check(vecs[i].name, 32'({st, fab_rst_n, train, terr}),
            32'({vecs[i].est, vecs[i].efab, vecs[i].eiod, vecs[i].eerr}));
    end

    // Stretch aborted at count 8 by a lock drop, then a full stretch after re-lock.
    tick(3);
    check("sa_enter", 32'(st), 32'd4);
    tick(8);
    check("sa_cnt8", 32'(st), 32'd4);
    lock = 1'b0;
    iod_seen = 1'b0;
    fab_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (train) iod_seen = 1'b1;
      if (fab_rst_n) fab_seen = 1'b1;
      if (i == 1) check("sa_still_str", 32'(st), 32'd4);
      if (i == 2) check("sa_to_lock", 32'(st), 32'd3);
    end
    check("sa_no_iod", 32'(iod_seen), 32'd0);
    check("sa_no_fab", 32'(fab_seen), 32'd0);
    check("sa_wait", 32'(st), 32'd3);

    lock  = 1'b1;
    n_str = 0;
    done  = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick(1);
      if (st == 3'd4) n_str++;
      else if (st == 3'd5) done = 1'b1;
    end
    check("sa_reached_run", 32'(done), 32'd1);
    check("sa_stretch_len", n_str, 32'd16);
    check("sa_iod", 32'({fab_rst_n, train}), 32'b11);
    tick(1);
    check("sa_iod_off", 32'({fab_rst_n, train}), 32'b10);

    // Asynchronous reset mid-cycle, away from any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'({st, fab_rst_n, train, terr}), 32'd0);
    tick(2);
    check("async_hold", 32'({st, fab_rst_n, train, terr}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
